id_hazard_stage: RTL
====================

ID_HAZARD_STAGE -- requirements
Module: id_hazard_stage

Interface
REQ-001 Parameters SHALL be: DATA_W, 32, datapath width | ADDR_W, 5, register address width (2**ADDR_W registers) | PC_W, 32, PC width | CNT_W, 32, statistics counter width.
REQ-002 Clocking SHALL be one clock; reset is synchronous and active-high; ports are named clk and rst.
REQ-003 Ports SHALL be (name direction width meaning), clock and reset first:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- instrF  in  32  fetched instruction
- pcF  in  PC_W  PC of instrF
- validF  in  1  instrF valid
- Regfile_weE / memReadE  in  1 / 1  EX writes reg / EX is load
- writeRegAddrE  in  ADDR_W  EX destination
- Regfile_weM / memReadM  in  1 / 1  MEM writes reg / MEM is load
- writeRegAddrM  in  ADDR_W  MEM destination
- aluOutM  in  DATA_W  MEM forward value
- Regfile_weW  in  1  WB write enable
- writeRegAddrW  in  ADDR_W  WB destination
- wbOut  in  DATA_W  WB data
- validD  out  1  IF/ID holds a live instruction
- instrD / pcD  out  32 / PC_W  registered instruction / PC
- rsD, rtD, rdD  out  ADDR_W  decoded fields
- imm16D  out  16  immediate
- readData1D / readData2D  out  DATA_W  forwarded operands
- stallF  out  1  hold PC and IF/ID
- bubbleE  out  1  insert NOP into EX
- branchTakenD  out  1  redirect fetch
- branchTargetD  out  PC_W  redirect address
- stallCnt / branchCnt  out  CNT_W  statistics

Function
REQ-004 IF/ID register SHALL capture instrF, pcF, validF at each clock edge unless stallF=1 (hold) or branchTakenD=1 (load validD=0, instrD=0); update priority: rst > stall > flush > load.
REQ-005 Latency SHALL be one cycle: instruction presented at F in cycle n drives the D outputs in cycle n+1.
REQ-006 Register file SHALL hold 2**ADDR_W entries of DATA_W; write on clk edge when Regfile_weW=1 and writeRegAddrW≠0; register 0 always reads 0.
REQ-007 Operand forwarding, per operand, SHALL select: MEM (aluOutM) if Regfile_weM, !memReadM, writeRegAddrM≠0 and address match; else WB (wbOut) under ID_WB_BYPASS_EN rules; else register file.
REQ-008 Both rs and rt SHALL be treated as sources for every valid instruction.
REQ-009 stall SHALL assert when validD=1 and any of: (a) memReadE, Regfile_weE, writeRegAddrE≠0, matches rs/rt; (b) branch in D and Regfile_weE, writeRegAddrE≠0, match; (c) memReadM, Regfile_weM, writeRegAddrM≠0, match.
REQ-010 stallF and bubbleE SHALL both equal stall; outputs are combinational from IF/ID state and hazard inputs.
REQ-011 Branches SHALL be opcode 000100 (BEQ, taken if equal) and 000101 (BNE, taken if unequal), compared on forwarded operands.
REQ-012 branchTakenD SHALL assert only when validD=1, stall=0, and the condition holds; there is no delay slot.
REQ-013 branchTargetD SHALL be pcD + 4 + (sign-extended imm16D << 2), modulo 2**PC_W.
REQ-014 stallCnt SHALL increment each cycle stallF=1; branchCnt SHALL increment each cycle branchTakenD=1; both wrap at 2**CNT_W.

Reset
REQ-015 On rst=1 at a clock edge, the block SHALL clear validD, instrD, pcD, stallCnt, branchCnt and all registers to 0.
REQ-016 While validD=0, stallF, bubbleE and branchTakenD SHALL be 0.
REQ-017 Reset asserted mid-stall SHALL discard the held instruction; the first post-reset edge with validF=1 SHALL load normally.

Configuration
REQ-018 Macro ID_WB_BYPASS_EN SHALL control WB handling. Defined: a matching WB write (weW, addr≠0) forwards wbOut in the same cycle. Undefined: no WB forwarding; such a match adds hazard condition (d) to REQ-009, stalling one cycle.

Verification
REQ-019 Reset, then feed ADD $3,$1,$2 at pcF=0x100 -> next cycle validD=1, pcD=0x100, rsD=1, rtD=2, rdD=3, stallF=0.
REQ-020 EX is LW to $5 (memReadE=1) and D uses rs=$5 -> stallF=bubbleE=1 for one cycle, IF/ID held, stallCnt=1.
REQ-021 BEQ $1,$2,+4 at pcD=0x200 with aluOutM=7 forwarded to $1 and reg $2=7 -> branchTakenD=1, branchTargetD=0x214, next cycle validD=0, branchCnt=1.
REQ-022 BNE with writeRegAddrE matching rt -> one-cycle stall with branchTakenD=0, then resolves on forwarded MEM value.
REQ-023 WB writes $4=0xDEAD while D reads $4 -> readData1D=0xDEAD with ID_WB_BYPASS_EN; without it, stallF=1 one cycle, then 0xDEAD.
REQ-024 Write $0=5, read rs=0 -> readData1D=0; assert rst during a stall -> validD=0 and counters 0 next cycle.

Source files
------------

// File: rtl/id_hazard_stage.sv
// id_hazard_stage: IF/ID pipeline register, register file, decode-stage operand
// forwarding, load-use / branch hazard detection, early branch resolution and
// stall/branch statistics counters.
// Configuration macro: ID_WB_BYPASS_EN
//   defined   -> a matching WB write is forwarded to the decode operands in the same cycle
//   undefined -> a matching WB write stalls decode for one cycle until the write lands
module id_hazard_stage #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int PC_W   = 32,
   parameter int CNT_W  = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [31:0]       instrF,
   input  logic [PC_W-1:0]   pcF,
   input  logic              validF,
   input  logic              Regfile_weE,
   input  logic              memReadE,
   input  logic [ADDR_W-1:0] writeRegAddrE,
   input  logic              Regfile_weM,
   input  logic              memReadM,
   input  logic [ADDR_W-1:0] writeRegAddrM,
   input  logic [DATA_W-1:0] aluOutM,
   input  logic              Regfile_weW,
   input  logic [ADDR_W-1:0] writeRegAddrW,
   input  logic [DATA_W-1:0] wbOut,
   output logic              validD,
   output logic [31:0]       instrD,
   output logic [PC_W-1:0]   pcD,
   output logic [ADDR_W-1:0] rsD,
   output logic [ADDR_W-1:0] rtD,
   output logic [ADDR_W-1:0] rdD,
   output logic [15:0]       imm16D,
   output logic [DATA_W-1:0] readData1D,
   output logic [DATA_W-1:0] readData2D,
   output logic              stallF,
   output logic              bubbleE,
   output logic              branchTakenD,
   output logic [PC_W-1:0]   branchTargetD,
   output logic [CNT_W-1:0]  stallCnt,
   output logic [CNT_W-1:0]  branchCnt
);

   localparam int         NREG   = 2 ** ADDR_W;
   localparam logic [5:0] OP_BEQ = 6'b000100;
   localparam logic [5:0] OP_BNE = 6'b000101;

   logic              ifidValid_q, ifidValid_d;
   logic [31:0]       ifidInstr_q, ifidInstr_d;
   logic [PC_W-1:0]   ifidPc_q, ifidPc_d;
   logic [CNT_W-1:0]  stallCnt_q, stallCnt_d;
   logic [CNT_W-1:0]  branchCnt_q, branchCnt_d;
   logic [DATA_W-1:0] regFile_q [NREG];

   logic [5:0]        opcode;
   logic              isBranch;
   logic [DATA_W-1:0] rfRead1, rfRead2;
   logic [DATA_W-1:0] fwd1, fwd2;
   logic              matchE, matchM, matchW;
   logic              stall;
   logic              branchCond;
   logic              branchTaken;
   logic [PC_W-1:0]   immExt;

   // Field decode straight out of the IF/ID register (MIPS R/I layout)
   assign opcode   = ifidInstr_q[31:26];
   assign rsD      = ADDR_W'(ifidInstr_q[25:21]);
   assign rtD      = ADDR_W'(ifidInstr_q[20:16]);
   assign rdD      = ADDR_W'(ifidInstr_q[15:11]);
   assign imm16D   = ifidInstr_q[15:0];
   assign isBranch = (opcode == OP_BEQ) || (opcode == OP_BNE);

   // Register 0 is hardwired to zero regardless of what was written there
   assign rfRead1 = (rsD == '0) ? '0 : regFile_q[rsD];
   assign rfRead2 = (rtD == '0) ? '0 : regFile_q[rtD];

   // Operand selection: MEM result beats WB data, which beats the register file
   always_comb begin
      fwd1 = rfRead1;
      fwd2 = rfRead2;
`ifdef ID_WB_BYPASS_EN
      if (Regfile_weW && (writeRegAddrW != '0) && (writeRegAddrW == rsD)) fwd1 = wbOut;
      if (Regfile_weW && (writeRegAddrW != '0) && (writeRegAddrW == rtD)) fwd2 = wbOut;
`endif
      if (Regfile_weM && !memReadM && (writeRegAddrM != '0) && (writeRegAddrM == rsD)) fwd1 = aluOutM;
      if (Regfile_weM && !memReadM && (writeRegAddrM != '0) && (writeRegAddrM == rtD)) fwd2 = aluOutM;
   end

   // Hazard detection: both rs and rt count as sources for every live instruction
   always_comb begin
      matchE = Regfile_weE && (writeRegAddrE != '0) &&
               ((writeRegAddrE == rsD) || (writeRegAddrE == rtD));
      matchM = Regfile_weM && (writeRegAddrM != '0) &&
               ((writeRegAddrM == rsD) || (writeRegAddrM == rtD));
      matchW = Regfile_weW && (writeRegAddrW != '0) &&
               ((writeRegAddrW == rsD) || (writeRegAddrW == rtD));
      stall  = 1'b0;
      if (ifidValid_q) begin
         if (memReadE && matchE) stall = 1'b1;
         if (isBranch && matchE) stall = 1'b1;
         if (memReadM && matchM) stall = 1'b1;
`ifndef ID_WB_BYPASS_EN
         if (matchW) stall = 1'b1;
`endif
      end
   end

   // Branch resolution on forwarded operands; a stalled branch never redirects
   always_comb begin
      branchCond = 1'b0;
      if (opcode == OP_BEQ) branchCond = (fwd1 == fwd2);
      if (opcode == OP_BNE) branchCond = (fwd1 != fwd2);
      branchTaken = ifidValid_q && !stall && isBranch && branchCond;
      immExt      = PC_W'($signed(ifidInstr_q[15:0]));
   end

   // IF/ID next state: hold on stall, squash on taken branch, otherwise load fetch
   always_comb begin
      ifidValid_d = ifidValid_q;
      ifidInstr_d = ifidInstr_q;
      ifidPc_d    = ifidPc_q;
      if (stall) begin
         ifidValid_d = ifidValid_q;
      end else if (branchTaken) begin
         ifidValid_d = 1'b0;
         ifidInstr_d = '0;
         ifidPc_d    = pcF;
      end else begin
         ifidValid_d = validF;
         ifidInstr_d = instrF;
         ifidPc_d    = pcF;
      end
      stallCnt_d  = stallCnt_q + CNT_W'(stall);
      branchCnt_d = branchCnt_q + CNT_W'(branchTaken);
   end

   // IF/ID register and statistics counters
   always_ff @(posedge clk) begin
      if (rst) begin
         ifidValid_q <= 1'b0;
         ifidInstr_q <= '0;
         ifidPc_q    <= '0;
         stallCnt_q  <= '0;
         branchCnt_q <= '0;
      end else begin
         ifidValid_q <= ifidValid_d;
         ifidInstr_q <= ifidInstr_d;
         ifidPc_q    <= ifidPc_d;
         stallCnt_q  <= stallCnt_d;
         branchCnt_q <= branchCnt_d;
      end
   end

   // Register file write port, driven by the WB stage
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) regFile_q[i] <= '0;
      end else if (Regfile_weW && (writeRegAddrW != '0)) begin
         regFile_q[writeRegAddrW] <= wbOut;
      end
   end

   assign validD        = ifidValid_q;
   assign instrD        = ifidInstr_q;
   assign pcD           = ifidPc_q;
   assign readData1D    = fwd1;
   assign readData2D    = fwd2;
   assign stallF        = stall;
   assign bubbleE       = stall;
   assign branchTakenD  = branchTaken;
   assign branchTargetD = ifidPc_q + PC_W'(4) + (immExt << 2);
   assign stallCnt      = stallCnt_q;
   assign branchCnt     = branchCnt_q;

endmodule
